// File: rtl/usb_pkg.sv
// ----------------------------------------------------------------------------
// usb_pkg
// Shared USB definitions for the TX packet framer and the RX decode path.
// Contents:
//   pid_e       - 4-bit PID codes (tokens, data, handshakes)
//   SYNC_BYTE   - first byte of every full-speed packet
//   CRC16_*     - polynomial (normal form), reflected form, initial value
//   state_t     - framer FSM state encoding
//   pid_is_data / pid_is_handshake - PID class helpers
// ----------------------------------------------------------------------------
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_e;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    // Bits go out LSB first, so the register shifts right and uses the
    // bit-reversed polynomial.
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SYNC   = 3'd1;
    localparam state_t ST_PID    = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CRC_LO = 3'd4;
    localparam state_t ST_CRC_HI = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic pid_is_handshake(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// ----------------------------------------------------------------------------
// usb_crc16
// Byte-wide USB CRC16 (x^16+x^15+x^2+1), LSB-first, one byte per clock.
// Shared between the TX framer and the RX CRC check.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, loads CRC16_INIT
//   clr  - synchronous clear, loads CRC16_INIT (start of a packet)
//   en   - fold data into the register this cycle
//   data - byte to fold in
//   crc  - current register value (not inverted)
// ----------------------------------------------------------------------------
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc16_next(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC16_POLY_R;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_next(crc, data);
        end
    end

endmodule

// File: rtl/usb_tx_packet_framer.sv
// ----------------------------------------------------------------------------
// usb_tx_packet_framer
// Builds a device-to-host USB packet as a byte stream for the NRZI/bit-stuff
// serializer: SYNC, PID, then for DATA0/DATA1 the payload from the TX FIFO
// followed by the inverted CRC16 (low byte, high byte).
// Build option:
//   USB_TX_LEN_CHECK_EN - when defined, a data_len above MAX_PKT_BYTES is
//                         rejected with tx_err; otherwise it is clamped.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   tx_start            - start request (sampled in IDLE only)
//   tx_pid, data_len    - PID and payload length, latched on tx_start
//   fifo_rdata/empty    - TX FIFO head byte and empty flag
//   fifo_pop            - pops the FIFO head on a payload transfer
//   tx_byte/valid/ready - byte handshake to the serializer
//   tx_last             - marks the final byte of the packet
//   tx_busy             - packet in progress
//   tx_done             - one-cycle pulse after the final transfer
//   tx_err              - one-cycle pulse on rejected request or underrun
// ----------------------------------------------------------------------------
module usb_tx_packet_framer
    import usb_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 64,
    parameter int LEN_W         = 7
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] data_len,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    output logic [7:0]       tx_byte,
    output logic             tx_byte_valid,
    input  logic             tx_byte_ready,
    output logic             tx_last,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] cnt_q;
    logic [3:0]       starve_q;
    logic             underrun_q;
    logic             err_d;

    logic [LEN_W-1:0] len_eff;
    logic             len_ok;
    logic             start_ok;
    logic             accept;
    logic             xfer;
    logic             starve_hit;
    logic [15:0]      crc;
    logic [15:0]      crc_tx;

    always_comb begin
        len_eff = (data_len > MAX_LEN) ? MAX_LEN : data_len;
    end

`ifdef USB_TX_LEN_CHECK_EN
    assign len_ok = !(pid_is_data(tx_pid) && (data_len > MAX_LEN));
`else
    assign len_ok = 1'b1;
`endif

    assign start_ok = (pid_is_data(tx_pid) || pid_is_handshake(tx_pid)) && len_ok;
    assign accept   = (state_q == ST_IDLE) && tx_start && start_ok;
    assign xfer     = tx_byte_valid && tx_byte_ready;

    // Sixteen consecutive empty cycles in DATA: this cycle is the 16th.
    assign starve_hit = (state_q == ST_DATA) && fifo_empty && (starve_q == 4'hF);

    // After an underrun the CRC goes out un-inverted, i.e. bit-inverted
    // relative to the correct value, so the host rejects the packet.
    assign crc_tx = underrun_q ? crc : ~crc;

    usb_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (fifo_pop),
        .data (fifo_rdata),
        .crc  (crc)
    );

    // Byte presented to the serializer, derived from state only so it holds
    // steady while the serializer stalls.
    always_comb begin
        tx_byte       = 8'h00;
        tx_byte_valid = 1'b0;
        tx_last       = 1'b0;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_SYNC: begin
                tx_byte       = SYNC_BYTE;
                tx_byte_valid = 1'b1;
            end
            ST_PID: begin
                tx_byte       = {~pid_q, pid_q};
                tx_byte_valid = 1'b1;
                tx_last       = pid_is_handshake(pid_q);
            end
            ST_DATA: begin
                tx_byte       = fifo_rdata;
                tx_byte_valid = !fifo_empty;
                fifo_pop      = !fifo_empty && tx_byte_ready;
            end
            ST_CRC_LO: begin
                tx_byte       = crc_tx[7:0];
                tx_byte_valid = 1'b1;
            end
            ST_CRC_HI: begin
                tx_byte       = crc_tx[15:8];
                tx_byte_valid = 1'b1;
                tx_last       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign tx_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign tx_done = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    if (start_ok) begin
                        state_d = ST_SYNC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (xfer) state_d = ST_PID;
            end
            ST_PID: begin
                if (xfer) begin
                    if (!pid_is_data(pid_q)) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_CRC_LO;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer && (cnt_q == LEN_W'(1))) begin
                    state_d = ST_CRC_LO;
                end else if (starve_hit) begin
                    state_d = ST_CRC_LO;
                    err_d   = 1'b1;
                end
            end
            ST_CRC_LO: begin
                if (xfer) state_d = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                if (xfer) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: reset applies here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= 4'd0;
            underrun_q <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_err  <= err_d;
            if (accept) begin
                underrun_q <= 1'b0;
            end else if (starve_hit) begin
                underrun_q <= 1'b1;
            end
            if ((state_q == ST_DATA) && fifo_empty) begin
                starve_q <= starve_q + 4'd1;
            end else begin
                starve_q <= 4'd0;
            end
        end
    end

    // Request fields: only meaningful once a packet has been accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            pid_q <= tx_pid;
            cnt_q <= len_eff;
        end else if (fifo_pop) begin
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
module tb_usb_tx_packet_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] data_len;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;
    logic       tx_last;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    always #5 clk = ~clk;

    usb_tx_packet_framer #(.MAX_PKT_BYTES(64), .LEN_W(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .data_len      (data_len),
        .fifo_rdata    (fifo_rdata),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .tx_last       (tx_last),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_err        (tx_err)
    );

    // FIFO model
    logic [7:0] fifo_mem [0:127];
    int         fifo_head;
    int         fifo_cnt;
    assign fifo_rdata = fifo_mem[fifo_head[6:0]];
    assign fifo_empty = (fifo_cnt == 0);

    typedef struct {
        logic [3:0] pid;
        logic [6:0] len;
        logic [7:0] pid_byte;
        bit         is_data;
        int         n_pay;
        logic [7:0] base;
        bit         rnd;
        bit         exp_err;
    } vec_t;

    vec_t vecs [0:10];

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] cap_byte [0:127];
    logic       cap_last [0:127];
    int n_cap, n_pop, n_err, n_done, stab_err, cyc, pop_cyc, err_cyc;
    bit busy_seen, rand_rdy, hold_v, pop_now;
    logic [7:0] hold_b;
    logic hold_l;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC: MSB-first form on bit-reflected input, reflected at end.
    function automatic logic [15:0] crc_ref(input logic [7:0] base, input int n);
        logic [15:0] r;
        logic [15:0] o;
        logic [7:0]  d;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            d = 8'(int'(base) + k);
            for (int i = 0; i < 8; i++) begin
                fb = r[15] ^ d[i];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) o[i] = r[15-i];
        return o;
    endfunction

    task automatic load_fifo(input int n, input logic [7:0] base);
        fifo_head = 0;
        fifo_cnt  = n;
        for (int i = 0; i < 128; i++) fifo_mem[i] = 8'(int'(base) + i);
    endtask

    task automatic clear_capture();
        n_cap = 0; n_pop = 0; n_err = 0; n_done = 0; stab_err = 0;
        cyc = 0; pop_cyc = -1; err_cyc = -1; busy_seen = 0; hold_v = 0;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        if (hold_v) begin
            if (!(tx_byte_valid && tx_byte === hold_b && tx_last === hold_l)) stab_err++;
        end
        hold_v = tx_byte_valid && !tx_byte_ready;
        hold_b = tx_byte;
        hold_l = tx_last;
        if (tx_byte_valid && tx_byte_ready) begin
            if (n_cap < 128) begin
                cap_byte[n_cap] = tx_byte;
                cap_last[n_cap] = tx_last;
            end
            n_cap++;
        end
        pop_now = fifo_pop;
        if (fifo_pop) begin n_pop++; pop_cyc = cyc; end
        if (tx_err) begin n_err++; err_cyc = cyc; end
        if (tx_done) n_done++;
        if (tx_busy) busy_seen = 1;
        @(posedge clk);
        #1;
        if (pop_now && fifo_cnt > 0) begin fifo_head++; fifo_cnt--; end
        tx_start      = 1'b0;
        tx_byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc++;
    endtask

    task automatic drive_packet(input logic [3:0] pid, input logic [6:0] len, input int budget);
        clear_capture();
        tx_pid   = pid;
        data_len = len;
        tx_start = 1'b1;
        for (int c = 0; c < budget && n_done == 0; c++) run_cycle();
        run_cycle();
    endtask

    task automatic check_packet(input int vi, input vec_t v);
        logic [7:0] expb [0:127];
        logic [15:0] crc_tx;
        int nb;
        if (v.exp_err) begin
            check($sformatf("v%0d err", vi), n_err, 1);
            check($sformatf("v%0d nbytes", vi), n_cap, 0);
            check($sformatf("v%0d busy", vi), int'(busy_seen), 0);
            check($sformatf("v%0d pops", vi), n_pop, 0);
            check($sformatf("v%0d done", vi), n_done, 0);
            return;
        end
        nb = 0;
        expb[nb++] = 8'h80;
        expb[nb++] = v.pid_byte;
        for (int i = 0; i < v.n_pay; i++) expb[nb++] = 8'(int'(v.base) + i);
        if (v.is_data) begin
            crc_tx = ~crc_ref(v.base, v.n_pay);
            expb[nb++] = crc_tx[7:0];
            expb[nb++] = crc_tx[15:8];
        end
        check($sformatf("v%0d nbytes", vi), n_cap, nb);
        for (int i = 0; i < nb && i < n_cap; i++) begin
            check($sformatf("v%0d byte%0d", vi, i), int'(cap_byte[i]), int'(expb[i]));
            check($sformatf("v%0d last%0d", vi, i), int'(cap_last[i]), int'(i == nb - 1));
        end
        check($sformatf("v%0d err", vi), n_err, 0);
        check($sformatf("v%0d pops", vi), n_pop, v.n_pay);
        check($sformatf("v%0d done", vi), n_done, 1);
        check($sformatf("v%0d stable", vi), stab_err, 0);
        check($sformatf("v%0d busy_end", vi), int'(tx_busy), 0);
    endtask

    initial begin
        vec_t v;
        logic [15:0] raw;

        //               pid      len    pidbyte dat  npay base   rnd  err
        vecs[0]  = '{4'b0010, 7'd0,   8'hD2, 1'b0, 0,  8'h00, 1'b0, 1'b0}; // ACK
        vecs[1]  = '{4'b1010, 7'd5,   8'h5A, 1'b0, 0,  8'h00, 1'b1, 1'b0}; // NAK
        vecs[2]  = '{4'b1110, 7'd0,   8'h1E, 1'b0, 0,  8'h00, 1'b0, 1'b0}; // STALL
        vecs[3]  = '{4'b0011, 7'd0,   8'hC3, 1'b1, 0,  8'h00, 1'b0, 1'b0}; // DATA0 empty
        vecs[4]  = '{4'b1011, 7'd4,   8'h4B, 1'b1, 4,  8'h00, 1'b1, 1'b0}; // DATA1 4
        vecs[5]  = '{4'b0011, 7'd1,   8'hC3, 1'b1, 1,  8'hA5, 1'b1, 1'b0}; // DATA0 1
        vecs[6]  = '{4'b1001, 7'd0,   8'h00, 1'b0, 0,  8'h00, 1'b0, 1'b1}; // IN
        vecs[7]  = '{4'b0001, 7'd0,   8'h00, 1'b0, 0,  8'h00, 1'b0, 1'b1}; // OUT
        vecs[8]  = '{4'b0011, 7'd64,  8'hC3, 1'b1, 64, 8'h30, 1'b1, 1'b0}; // max
`ifdef USB_TX_LEN_CHECK_EN
        vecs[9]  = '{4'b1011, 7'd100, 8'h4B, 1'b1, 0,  8'h40, 1'b0, 1'b1}; // too long
`else
        vecs[9]  = '{4'b1011, 7'd100, 8'h4B, 1'b1, 64, 8'h40, 1'b0, 1'b0}; // clamped
`endif
        vecs[10] = '{4'b1101, 7'd2,   8'h00, 1'b0, 0,  8'h00, 1'b0, 1'b1}; // SETUP

        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; data_len = 7'd0;
        tx_byte_ready = 1'b1; rand_rdy = 1'b0;
        load_fifo(0, 8'h00);
        clear_capture();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              int'({tx_byte_valid, tx_last, tx_busy, tx_done, tx_err, fifo_pop}), 0);
        check("reset byte", int'(tx_byte), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ACK latency, cycle by cycle
        tx_pid = 4'b0010; data_len = 7'd0; tx_start = 1'b1;
        @(negedge clk);
        check("ack c0 valid", int'(tx_byte_valid), 0);
        @(posedge clk); #1; tx_start = 1'b0;
        @(negedge clk);
        check("ack c1 valid", int'(tx_byte_valid), 1);
        check("ack c1 byte", int'(tx_byte), 8'h80);
        check("ack c1 busy", int'(tx_busy), 1);
        @(negedge clk);
        check("ack c2 byte", int'(tx_byte), 8'hD2);
        check("ack c2 last", int'(tx_last), 1);
        @(negedge clk);
        check("ack c3 done", int'(tx_done), 1);
        check("ack c3 busy", int'(tx_busy), 0);
        check("ack c3 valid", int'(tx_byte_valid), 0);
        @(negedge clk);
        check("ack c4 done", int'(tx_done), 0);
        @(posedge clk); #1;

        // Table-driven packets
        for (int vi = 0; vi <= 10; vi++) begin
            load_fifo(vecs[vi].n_pay, vecs[vi].base);
            rand_rdy = vecs[vi].rnd;
            drive_packet(vecs[vi].pid, vecs[vi].len, vecs[vi].exp_err ? 6 : 400);
            rand_rdy = 1'b0;
            check_packet(vi, vecs[vi]);
        end

        // Underrun: 3 bytes announced, only 1 available
        load_fifo(1, 8'hA5);
        drive_packet(4'b0011, 7'd3, 200);
        raw = crc_ref(8'hA5, 1);
        check("urun nbytes", n_cap, 5);
        check("urun b0", int'(cap_byte[0]), 8'h80);
        check("urun b1", int'(cap_byte[1]), 8'hC3);
        check("urun b2", int'(cap_byte[2]), 8'hA5);
        check("urun crc lo", int'(cap_byte[3]), int'(raw[7:0]));
        check("urun crc hi", int'(cap_byte[4]), int'(raw[15:8]));
        check("urun last", int'(cap_last[4]), 1);
        check("urun err", n_err, 1);
        check("urun err delay", err_cyc - pop_cyc, 17);
        check("urun pops", n_pop, 1);
        check("urun done", n_done, 1);

        // Reset in the middle of DATA
        load_fifo(1, 8'h11);
        clear_capture();
        tx_pid = 4'b0011; data_len = 7'd2; tx_start = 1'b1;
        repeat (6) run_cycle();
        check("mid pops", n_pop, 1);
        check("mid busy", int'(tx_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst busy", int'(tx_busy), 0);
        check("rst valid", int'(tx_byte_valid), 0);
        check("rst pop", int'(fifo_pop), 0);
        rst = 1'b0;
        v = vecs[3];
        load_fifo(0, 8'h00);
        drive_packet(v.pid, v.len, 50);
        check_packet(20, v);
        v = vecs[0];
        drive_packet(v.pid, v.len, 50);
        check_packet(21, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_packet_framer.md
Name: usb_tx_packet_framer

Overview:
- Transmit-side counterpart to the USB receive PID/packet decode path.
- On a start request, emits a complete device-to-host packet as a byte stream to the NRZI/bit-stuff serializer:
  - SYNC byte, then PID byte.
  - For data packets: payload bytes pulled from the TX FIFO, then CRC16 low and high bytes.
- Sits between the protocol controller (which picks the PID and length) and the byte serializer.

Parameters:
- MAX_PKT_BYTES, 64, largest data payload in bytes.
- LEN_W, 7, width of the data_len input; must satisfy 2^LEN_W > MAX_PKT_BYTES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tx_start  in  1  one-cycle request to start a packet; sampled only in IDLE
- tx_pid  in  4  PID code; latched on tx_start
- data_len  in  LEN_W  payload byte count for DATA0/DATA1; latched on tx_start
- fifo_rdata  in  8  head-of-FIFO byte, combinationally valid while fifo_empty=0
- fifo_empty  in  1  TX FIFO empty
- fifo_pop  out  1  pops the FIFO head; asserted in the cycle a payload byte handshakes
- tx_byte  out  8  byte to serializer, LSB transmitted first
- tx_byte_valid  out  1  tx_byte is valid
- tx_byte_ready  in  1  serializer accepts the byte
- tx_last  out  1  qualifies tx_byte as the final byte; serializer appends EOP after it
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle pulse after the last byte handshakes
- tx_err  out  1  one-cycle pulse on a rejected PID or FIFO underrun

Behaviour:
- Reset values: all outputs 0; state IDLE; CRC register 16'hFFFF.
- Legal PIDs:
  - Data: DATA0 4'b0011, DATA1 4'b1011.
  - Handshake: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - Any other value at tx_start: tx_err pulses next cycle, state stays IDLE, no byte is emitted.
- Byte handshake: a byte transfers on a cycle with tx_byte_valid && tx_byte_ready. tx_byte and tx_last hold stable while valid and not ready. valid is never withdrawn before transfer.
- FSM states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, DONE.
- IDLE: on tx_start with a legal PID, go to SYNC next cycle; tx_busy=1 from that cycle until DONE.
- SYNC: tx_byte=8'h80.
- PID: tx_byte={~pid,pid}.
  - Handshake PID: tx_last=1; go to DONE.
  - Data PID with data_len=0: go to CRC_LO.
  - Data PID with data_len>0: go to DATA.
- DATA:
  - tx_byte=fifo_rdata; valid only while fifo_empty=0.
  - Each transfer: fifo_pop=1, CRC updated with the byte, byte counter decremented. Counter reaching 0 moves to CRC_LO.
  - Underrun: fifo_empty=1 in DATA for 16 consecutive cycles → tx_err pulse; emit CRC_LO/CRC_HI with the CRC bit-inverted, which corrupts the packet so the host discards it; then DONE.
- CRC rules:
  - CRC16 polynomial x^16+x^15+x^2+1, init 16'hFFFF, LSB-first update, one byte per cycle.
  - Transmitted value is ~crc: CRC_LO sends bits [7:0], CRC_HI sends bits [15:8] with tx_last=1.
- DONE: tx_done=1 for one cycle, tx_busy=0, return to IDLE. tx_start sampled in DONE is ignored.
- Boundaries:
  - tx_start while busy: ignored.
  - rst mid-packet: all outputs drop to 0 next cycle; the serializer treats a dropped valid as abort.
  - data_len > MAX_PKT_BYTES: truncated to MAX_PKT_BYTES unless the optional feature below is enabled.
- Latency:
  - tx_start → first tx_byte_valid: 1 cycle.
  - Last transfer → tx_done: 1 cycle.

Optional Feature:
- Macro USB_TX_LEN_CHECK_EN.
- Defined: data_len > MAX_PKT_BYTES at tx_start is rejected exactly like an illegal PID (tx_err pulse, stay IDLE).
- Undefined: the length is silently clamped to MAX_PKT_BYTES; no error.

Decomposition:
- Package usb_pkg:
  - PID enum (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL).
  - SYNC_BYTE=8'h80, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF.
  - FSM state typedef.
- Sub-module usb_crc16: byte-wide combinational next-CRC function plus register with clear and enable. Shared with the RX CRC check.

Test Plan:
- ACK request (tx_pid=4'b0010), ready held 1 → bytes 8'h80, 8'hD2 (tx_last=1); tx_done pulses 1 cycle later; no fifo_pop.
- DATA0 with data_len=0 → 8'h80, 8'hC3, 8'h00, 8'h00 (tx_last on the final byte); CRC equals ~16'hFFFF.
- DATA1, data_len=4, FIFO holds 00 01 02 03; ready toggles 1/0 randomly → 8'h80, 8'h4B, the 4 payload bytes, CRC bytes matching the reference model. Bytes stay stable while ready=0; exactly 4 fifo_pop pulses.
- tx_pid=4'b1001 (IN token) → tx_err pulse, no tx_byte_valid, tx_busy stays 0.
- DATA0, data_len=3, FIFO holds only 1 byte → after 16 empty cycles tx_err pulses; inverted CRC is sent; tx_done pulses.
- rst asserted during DATA → next cycle tx_busy=0, tx_byte_valid=0. A following ACK request transmits correctly with CRC reinitialised.
